c3_layer_sequencer: RTL and testbench
=====================================

# c3_layer_sequencer

Sequencer for the C3 convolution datapath. It walks every output position of the C3 feature map and pulses the window-fetch trigger for each anchor. It then steps the kernel/bias index through all kernels and writes each returned inner-product result to the C3 output-map RAM at a computed address. It sits between the layer-level control (start/done) and one C3 window/inner-product sub-module.

## Interface
Parameters:
- `OUT_W`, 10: output map width (columns).
- `OUT_H`, 10: output map height (rows).
- `FM_W`, 14: input feature-map row pitch in words.
- `N_KERNEL`, 16: kernels per anchor.
- `FETCH_CYC`, 6: cycles the sub-module needs to assemble a 5x5 window after the anchor pulse.
- `PIPE_LAT`, 3: cycles from kernel index issue to valid inner-product result.
- `ADDR_W`, 32: input address width.
- `WADDR_W`, 16: output RAM address width.

Ports:
- `clk`  in  1: clock; single clock domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to run the full layer.
- `abort`  in  1: synchronous abort; return to IDLE.
- `in_base`  in  ADDR_W: input map base address, sampled on accepted start.
- `busy`  out  1: high from accepted start until done.
- `done`  out  1: one-cycle pulse at layer completion.
- `anchor_valid`  out  1: one-cycle pulse that starts a window fetch.
- `anchor_addr`  out  ADDR_W: in_base + row*FM_W + col; valid while anchor_valid.
- `kernel_idx`  out  8: kernel/bias ROM index.
- `ip_data`  in  16: inner-product result from the datapath.
- `wr_en`  out  1: output RAM write strobe.
- `wr_addr`  out  WADDR_W: k*OUT_W*OUT_H + row*OUT_W + col.
- `wr_data`  out  16: registered ip_data.

## Operation
- States are IDLE → ANCHOR → FETCH → COMPUTE → (ANCHOR | DRAIN) → DONE → IDLE.
- IDLE: `start` is accepted. It latches `in_base` and clears row/col to 0.
- ANCHOR: 1 cycle. `anchor_valid`=1.
- FETCH: exactly FETCH_CYC cycles.
- COMPUTE: N_KERNEL cycles. `kernel_idx` counts 0..N_KERNEL-1 and a tag {k,row,col} enters a PIPE_LAT-deep delay line.
- After the last kernel, col increments. At col=OUT_W-1 it wraps to 0 and row increments.
- The state then goes to ANCHOR, or to DRAIN once row=OUT_H-1 and col=OUT_W-1 have been computed.
- DRAIN: stays until the delay line is empty, then moves to DONE. DONE lasts 1 cycle with `done`=1, then goes to IDLE.
- Writes from one anchor may overlap the next anchor's ANCHOR/FETCH states. A static assertion requires PIPE_LAT+1 ≤ 1+FETCH_CYC.
- `start` while busy is ignored. `start` coincident with DONE is ignored. It is accepted only in IDLE.
- `abort`, in any non-IDLE state:
  - next state is IDLE;
  - the delay line is flushed and no further `wr_en` occurs;
  - `done` is not pulsed.
- `abort` and `start` in the same IDLE cycle: abort wins and start is dropped.
- Address arithmetic:
  - Unsigned, truncated to the port width.
  - `wr_addr` uses constant multipliers. OUT_W*OUT_H*N_KERNEL must fit in WADDR_W.

## Timing
- Reset values: `busy`, `done`, `anchor_valid`, `wr_en` = 0. `kernel_idx`, `anchor_addr`, `wr_addr`, `wr_data` = 0. State is IDLE.
- `start` at cycle 0: `anchor_valid` and `busy` are high at cycle 1.
- The first `kernel_idx`=0 issues at cycle 2+FETCH_CYC.
- Kernel issued at cycle t: `ip_data` is sampled at t+PIPE_LAT, and `wr_en`/`wr_addr`/`wr_data` are valid at t+PIPE_LAT+1.
- Per anchor: 1+FETCH_CYC+N_KERNEL cycles.
- Total from start to `done`: OUT_W*OUT_H*(1+FETCH_CYC+N_KERNEL) + PIPE_LAT + 2 cycles.
- `busy` drops in the cycle after `done`.
- `kernel_idx` = 0 outside COMPUTE.
- All outputs are registered.

## Structure
- A shared package holds:
  - the state enum;
  - the C3 geometry constants (OUT_W, OUT_H, FM_W, N_KERNEL);
  - the datapath latency constants (FETCH_CYC, PIPE_LAT).
- One sub-module, `c3_tag_delay`: a PIPE_LAT-stage shift register carrying {valid,k,row,col} with a synchronous flush.

## Test plan
- Reset asserted mid-COMPUTE: all outputs return to 0 asynchronously, and state is IDLE after release.
- OUT_W=2, OUT_H=2, N_KERNEL=3, FETCH_CYC=6, PIPE_LAT=3, in_base=100, FM_W=14:
  - `anchor_addr` sequence is 100, 101, 114, 115;
  - 12 writes occur, with `wr_addr` = k*4 + row*2 + col;
  - `done` arrives at cycle 4*10+5 = 45 after start.
- Default parameters, `ip_data` driven as a counter: 1600 writes, each `wr_data` equals the `ip_data` from PIPE_LAT cycles after issue, and `done` arrives at cycle 2305.
- `start` re-pulsed during FETCH and in the DONE cycle: both are ignored, with no extra anchors.
- `abort` at the second COMPUTE cycle of anchor 3: no `wr_en` afterwards, no `done`, and a subsequent `start` reruns from anchor (0,0).
- `start` one cycle after `done`: a clean second run with identical write trace.

Source files
------------

// File: rtl/c3_layer_sequencer_pkg.sv
// Shared definitions for the C3 layer sequencer: state encoding, C3 geometry and
// datapath latency defaults, plus a counter-width helper.
package c3_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    C3_IDLE    = 3'd0,
    C3_ANCHOR  = 3'd1,
    C3_FETCH   = 3'd2,
    C3_COMPUTE = 3'd3,
    C3_DRAIN   = 3'd4,
    C3_DONE    = 3'd5
  } c3_state_e;

  localparam int C3_OUT_W     = 10;
  localparam int C3_OUT_H     = 10;
  localparam int C3_FM_W      = 14;
  localparam int C3_N_KERNEL  = 16;
  localparam int C3_FETCH_CYC = 6;
  localparam int C3_PIPE_LAT  = 3;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int c3_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/c3_tag_delay.sv
// Fixed-depth shift register carrying {valid, tag} alongside the inner-product
// pipeline; flush clears every valid bit in one cycle.
module c3_tag_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_tag,
  output logic         out_valid,
  output logic [W-1:0] out_tag,
  output logic         any_valid
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     tag [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else begin
      vld[0] <= in_valid & ~flush;
      tag[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1] & ~flush;
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_tag   = tag[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/c3_layer_sequencer.sv
// C3 layer sequencer: walks every output anchor, triggers the window fetch,
// issues all kernel indices and writes each returned inner product to the C3 map.
// state   | meaning
// IDLE    | waiting for start
// ANCHOR  | one-cycle anchor_valid for the current (row,col)
// FETCH   | FETCH_CYC cycles while the sub-module assembles the window
// COMPUTE | kernel_idx steps 0..N_KERNEL-1, tags enter the delay line
// DRAIN   | wait for the last tags to leave the delay line
// DONE    | one-cycle done pulse
module c3_layer_sequencer
  import c3_layer_sequencer_pkg::*;
#(
  parameter int OUT_W     = C3_OUT_W,
  parameter int OUT_H     = C3_OUT_H,
  parameter int FM_W      = C3_FM_W,
  parameter int N_KERNEL  = C3_N_KERNEL,
  parameter int FETCH_CYC = C3_FETCH_CYC,
  parameter int PIPE_LAT  = C3_PIPE_LAT,
  parameter int ADDR_W    = 32,
  parameter int WADDR_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  in_base,
  output logic               busy,
  output logic               done,
  output logic               anchor_valid,
  output logic [ADDR_W-1:0]  anchor_addr,
  output logic [7:0]         kernel_idx,
  input  logic [15:0]        ip_data,
  output logic               wr_en,
  output logic [WADDR_W-1:0] wr_addr,
  output logic [15:0]        wr_data
);

  localparam int ROW_W = c3_cnt_w(OUT_H);
  localparam int COL_W = c3_cnt_w(OUT_W);
  localparam int FC_W  = c3_cnt_w(FETCH_CYC);
  localparam int TAG_W = 8 + ROW_W + COL_W;

  localparam logic [2:0] S_IDLE    = C3_IDLE;
  localparam logic [2:0] S_ANCHOR  = C3_ANCHOR;
  localparam logic [2:0] S_FETCH   = C3_FETCH;
  localparam logic [2:0] S_COMPUTE = C3_COMPUTE;
  localparam logic [2:0] S_DRAIN   = C3_DRAIN;
  localparam logic [2:0] S_DONE    = C3_DONE;

  localparam logic [ADDR_W-1:0]  FM_PITCH  = ADDR_W'(FM_W);
  localparam logic [WADDR_W-1:0] ROW_PITCH = WADDR_W'(OUT_W);
  localparam logic [WADDR_W-1:0] K_PITCH   = WADDR_W'(OUT_W * OUT_H);

  // Results must land before the next anchor's first kernel is issued.
  generate
    if (PIPE_LAT < 1 || FETCH_CYC < 1 || PIPE_LAT + 1 > 1 + FETCH_CYC) begin : g_bad_latency
      $error("c3_layer_sequencer: need 1 <= PIPE_LAT <= FETCH_CYC");
    end
    if (N_KERNEL < 1 || N_KERNEL > 256 ||
        64'(OUT_W * OUT_H * N_KERNEL) > (64'd1 << WADDR_W)) begin : g_bad_geometry
      $error("c3_layer_sequencer: output map does not fit WADDR_W or kernel_idx");
    end
  endgenerate

  logic [2:0]         state, state_nx;
  logic [ROW_W-1:0]   row, row_nx;
  logic [COL_W-1:0]   col, col_nx;
  logic [ADDR_W-1:0]  base;
  logic [FC_W-1:0]    fetch_cnt;
  logic               last_k, last_pos;
  logic               tag_out_vld, pipe_busy;
  logic [TAG_W-1:0]   tag_out;
  logic [7:0]         t_k;
  logic [ROW_W-1:0]   t_row;
  logic [COL_W-1:0]   t_col;

  always_comb begin
    last_k   = (kernel_idx == 8'(N_KERNEL - 1));
    last_pos = (row == ROW_W'(OUT_H - 1)) && (col == COL_W'(OUT_W - 1));
    col_nx   = col + COL_W'(1);
    row_nx   = row;
    if (col == COL_W'(OUT_W - 1)) begin
      col_nx = '0;
      row_nx = row + ROW_W'(1);
    end

    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_ANCHOR;
      S_ANCHOR:  state_nx = S_FETCH;
      S_FETCH:   if (fetch_cnt == '0) state_nx = S_COMPUTE;
      S_COMPUTE: if (last_k) state_nx = last_pos ? S_DRAIN : S_ANCHOR;
      S_DRAIN:   if (!pipe_busy) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      base         <= '0;
      fetch_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      anchor_valid <= 1'b0;
      anchor_addr  <= '0;
      kernel_idx   <= '0;
    end else begin
      state        <= state_nx;
      busy         <= (state_nx != S_IDLE);
      done         <= (state_nx == S_DONE);
      anchor_valid <= (state_nx == S_ANCHOR);
      kernel_idx   <= (state == S_COMPUTE && state_nx == S_COMPUTE) ? kernel_idx + 8'd1 : 8'd0;

      if (state == S_ANCHOR) fetch_cnt <= FC_W'(FETCH_CYC - 1);
      else if (state == S_FETCH && fetch_cnt != '0) fetch_cnt <= fetch_cnt - FC_W'(1);

      if (state == S_IDLE && state_nx == S_ANCHOR) begin
        base        <= in_base;
        row         <= '0;
        col         <= '0;
        anchor_addr <= in_base;
      end else if (state == S_COMPUTE && state_nx == S_ANCHOR) begin
        row         <= row_nx;
        col         <= col_nx;
        anchor_addr <= base + ADDR_W'(row_nx) * FM_PITCH + ADDR_W'(col_nx);
      end
    end
  end

  c3_tag_delay #(
    .DEPTH (PIPE_LAT),
    .W     (TAG_W)
  ) u_tag_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .in_valid  (state == S_COMPUTE),
    .in_tag    ({kernel_idx, row, col}),
    .out_valid (tag_out_vld),
    .out_tag   (tag_out),
    .any_valid (pipe_busy)
  );

  assign {t_k, t_row, t_col} = tag_out;

  // A tag leaving the delay line in the abort cycle is dropped as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= tag_out_vld & ~abort;
      if (tag_out_vld) begin
        wr_addr <= WADDR_W'(t_k) * K_PITCH + WADDR_W'(t_row) * ROW_PITCH + WADDR_W'(t_col);
        wr_data <= ip_data;
      end
    end
  end

endmodule

// File: tb/tb_c3_layer_sequencer.sv
// Randomized bench for c3_layer_sequencer: a default-size and a 2x2x3 instance are
// driven in turn and their traces compared with a position/kernel reference model.
module tb_c3_layer_sequencer;

  localparam int F  = 6;
  localparam int PL = 3;
  localparam int FM = 14;

  logic clk = 1'b0;
  logic rst_n, start, abort, sel;
  logic [31:0] in_base;
  logic [15:0] ip_data, mul, add;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  logic        d_busy, d_done, d_av, d_wr_en, s_busy, s_done, s_av, s_wr_en;
  logic [31:0] d_aaddr, s_aaddr;
  logic [7:0]  d_kidx, s_kidx;
  logic [15:0] d_waddr, d_wdata, s_waddr, s_wdata;

  logic        m_busy, m_done, m_av, m_wr_en;
  logic [31:0] m_aaddr;
  logic [7:0]  m_kidx;
  logic [15:0] m_waddr, m_wdata;

  int ow = 10, oh = 10, nk = 16;
  int run_s = 0, exp_done = 0;
  bit chk_en = 0;
  logic [63:0] an_q[$], wr_q[$], exp_an[$], exp_wr[$];
  int done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ip_data = 16'(cyc * 32'(mul) + 32'(add));

  c3_layer_sequencer dut_d (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel), .in_base(in_base),
    .busy(d_busy), .done(d_done), .anchor_valid(d_av), .anchor_addr(d_aaddr),
    .kernel_idx(d_kidx), .ip_data(ip_data), .wr_en(d_wr_en), .wr_addr(d_waddr), .wr_data(d_wdata)
  );

  c3_layer_sequencer #(
    .OUT_W(2), .OUT_H(2), .FM_W(14), .N_KERNEL(3), .FETCH_CYC(6), .PIPE_LAT(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel), .in_base(in_base),
    .busy(s_busy), .done(s_done), .anchor_valid(s_av), .anchor_addr(s_aaddr),
    .kernel_idx(s_kidx), .ip_data(ip_data), .wr_en(s_wr_en), .wr_addr(s_waddr), .wr_data(s_wdata)
  );

  assign m_busy  = sel ? s_busy  : d_busy;
  assign m_done  = sel ? s_done  : d_done;
  assign m_av    = sel ? s_av    : d_av;
  assign m_wr_en = sel ? s_wr_en : d_wr_en;
  assign m_aaddr = sel ? s_aaddr : d_aaddr;
  assign m_kidx  = sel ? s_kidx  : d_kidx;
  assign m_waddr = sel ? s_waddr : d_waddr;
  assign m_wdata = sel ? s_wdata : d_wdata;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ipf(input int c);
    return 16'(c * 32'(mul) + 32'(add));
  endfunction

  // Expected {busy, kernel_idx} in cycle c of the current run.
  function automatic logic [8:0] exp_bk(input int c);
    int p, rel, k;
    logic b;
    p   = 1 + F + nk;
    rel = c - run_s - 1;
    k   = 0;
    b   = (rel >= 0) && (c <= exp_done);
    if (rel >= 0 && rel < ow * oh * p && (rel % p) >= 1 + F) k = (rel % p) - 1 - F;
    return {b, 8'(k)};
  endfunction

  always @(negedge clk) begin
    if (m_av)    an_q.push_back({32'(cyc), m_aaddr});
    if (m_wr_en) wr_q.push_back({32'(cyc), m_waddr, m_wdata});
    if (m_done)  done_q.push_back(cyc);
    if (chk_en)  chk("busy_kidx", 64'({m_busy, m_kidx}), 64'(exp_bk(cyc)));
  end

  task automatic build_model(input int s, input logic [31:0] base);
    int p, a, t;
    p = 1 + F + nk;
    a = 0;
    exp_an.delete();
    exp_wr.delete();
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        exp_an.push_back({32'(s + 1 + a * p), 32'(base + 32'(r * FM + c))});
        for (int k = 0; k < nk; k++) begin
          t = s + 2 + F + a * p + k;
          exp_wr.push_back({32'(t + PL + 1), 16'(k * ow * oh + r * ow + c), ipf(t + PL)});
        end
        a++;
      end
    end
    exp_done = s + ow * oh * p + PL + 2;
  endtask

  task automatic set_sel(input logic v);
    chk_en = 0;
    sel = v;
    ow = v ? 2 : 10;
    oh = v ? 2 : 10;
    nk = v ? 3 : 16;
  endtask

  // abort_at >= 0 aborts in the second COMPUTE cycle of that anchor index.
  task automatic run_layer(input string tag, input logic [31:0] base, input int extra,
                           input bit repulse, input int abort_at, output int lat);
    int s, abort_c, stop_c, n;
    logic [63:0] tmp;
    an_q.delete();
    wr_q.delete();
    done_q.delete();
    mul = 16'($urandom);
    add = 16'($urandom);
    s = cyc;
    in_base = base;
    start = 1'b1;
    build_model(s, base);
    run_s   = s;
    chk_en  = (abort_at < 0);
    abort_c = s + 2 + F + abort_at * (1 + F + nk) + 1;
    stop_c  = (abort_at < 0) ? exp_done + extra : abort_c + 20;
    while (cyc < stop_c) begin
      @(posedge clk);
      #1;
      start   = repulse && (cyc == s + 3 || cyc == exp_done);
      abort   = (abort_at >= 0) && (cyc == abort_c);
      in_base = $urandom;
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_at >= 0) begin
      while (exp_an.size() > 0) begin
        tmp = exp_an[exp_an.size() - 1];
        if (int'(tmp[63:32]) > abort_c) void'(exp_an.pop_back()); else break;
      end
      while (exp_wr.size() > 0) begin
        tmp = exp_wr[exp_wr.size() - 1];
        if (int'(tmp[63:32]) > abort_c) void'(exp_wr.pop_back()); else break;
      end
      chk({tag, "_done_cnt"}, 64'(done_q.size()), 64'd0);
      chk({tag, "_busy_after"}, 64'(m_busy), 64'd0);
    end else begin
      chk({tag, "_done_cnt"}, 64'(done_q.size()), 64'd1);
    end
    lat = (done_q.size() > 0) ? done_q[0] - s : -1;
    chk({tag, "_n_anchor"}, 64'(an_q.size()), 64'(exp_an.size()));
    n = (an_q.size() < exp_an.size()) ? an_q.size() : exp_an.size();
    for (int i = 0; i < n; i++) chk({tag, "_anchor"}, an_q[i], exp_an[i]);
    chk({tag, "_n_write"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, wr_q[i], exp_wr[i]);
  endtask

  initial begin
    int lat, s;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_base = '0; mul = '0; add = '0;
    set_sel(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({m_busy, m_done, m_av, m_wr_en}), 64'd0);
    chk("rst_kidx", 64'(m_kidx), 64'd0);
    chk("rst_aaddr", 64'(m_aaddr), 64'd0);
    chk("rst_waddr", 64'(m_waddr), 64'd0);
    chk("rst_wdata", 64'(m_wdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    set_sel(1'b1);
    run_layer("small", 32'd100, 3, 1'b0, -1, lat);
    chk("small_done_lat", 64'(lat), 64'd45);
    if (an_q.size() == 4) chk("small_anchor_last", 64'(an_q[3][31:0]), 64'd115);
    chk("small_n_write_abs", 64'(wr_q.size()), 64'd12);

    set_sel(1'b0);
    run_layer("full", $urandom, 3, 1'b0, -1, lat);
    chk("full_done_lat", 64'(lat), 64'd2305);
    chk("full_n_write_abs", 64'(wr_q.size()), 64'd1600);
    run_layer("repulse", $urandom, 10, 1'b1, -1, lat);
    run_layer("abort", $urandom, 0, 1'b0, 3, lat);
    run_layer("rerun", $urandom, 1, 1'b0, -1, lat);
    run_layer("b2b", $urandom, 3, 1'b0, -1, lat);
    chk("b2b_done_lat", 64'(lat), 64'd2305);

    chk_en = 0;
    s = cyc;
    in_base = $urandom;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < s + 2 + F + 5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 64'({m_busy, m_done, m_av, m_wr_en, m_kidx}), 64'd0);
    chk("rst_async_data", {m_aaddr, m_waddr, m_wdata}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    an_q.delete();
    wr_q.delete();
    done_q.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("rst_idle", 64'({m_busy, m_kidx}), 64'd0);
    chk("rst_idle_quiet", 64'(an_q.size() + wr_q.size() + done_q.size()), 64'd0);
    run_layer("post_rst", $urandom, 3, 1'b0, -1, lat);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
